// File: rtl/shift_sequencer_32.sv
// Iterative logical shifter: drives an external 2-bit shift stage once per cycle,
// finishing odd amounts with an internal 1-bit step, behind a START/BUSY/DONE handshake.
module shift_sequencer_32 #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             DIR_LEFT,
   input  logic [AMT_W-1:0] AMT,
   input  logic [WIDTH-1:0] DIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] DOUT,
   output logic             L_SHIFT,
   output logic             NO_SHIFT,
   output logic             R_SHIFT,
   output logic [WIDTH-1:0] STAGE_IN,
   input  logic [WIDTH-1:0] STAGE_OUT
);

   typedef enum logic [1:0] {IDLE, SHIFT2, SHIFT1, FIN} state_t;

   localparam logic [AMT_W-2:0] C_ONE  = {{(AMT_W-2){1'b0}}, 1'b1};
   localparam logic [AMT_W-2:0] C_ZERO = '0;

   state_t           state, state_next;
   logic [WIDTH-1:0] w, w_next;
   logic [WIDTH-1:0] dout, dout_next;
   logic [AMT_W-2:0] c, c_next;
   logic             odd, odd_next;
   logic             dir, dir_next;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         w     <= '0;
         dout  <= '0;
         c     <= '0;
         odd   <= 1'b0;
         dir   <= 1'b0;
      end else begin
         state <= state_next;
         w     <= w_next;
         dout  <= dout_next;
         c     <= c_next;
         odd   <= odd_next;
         dir   <= dir_next;
      end
   end

   // Stage controls and handshake decode from the registered state only.
   always_comb begin
      state_next = state;
      w_next     = w;
      c_next     = c;
      odd_next   = odd;
      dir_next   = dir;
      dout_next  = dout;
      BUSY       = 1'b0;
      DONE       = 1'b0;
      L_SHIFT    = 1'b0;
      R_SHIFT    = 1'b0;
      NO_SHIFT   = 1'b1;
      case (state)
         IDLE: begin
            if (START) begin
               w_next   = DIN;
               c_next   = AMT[AMT_W-1:1];
               odd_next = AMT[0];
               dir_next = DIR_LEFT;
               if (AMT[AMT_W-1:1] != C_ZERO) state_next = SHIFT2;
               else if (AMT[0])              state_next = SHIFT1;
               else                          state_next = FIN;
            end
         end
         SHIFT2: begin
            BUSY     = 1'b1;
            NO_SHIFT = 1'b0;
            L_SHIFT  = dir;
            R_SHIFT  = !dir;
            w_next   = STAGE_OUT;
            c_next   = c - C_ONE;
            if (c == C_ONE) state_next = odd ? SHIFT1 : FIN;
         end
         SHIFT1: begin
            BUSY       = 1'b1;
            w_next     = dir ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
            state_next = FIN;
         end
         FIN: begin
            BUSY       = 1'b1;
            DONE       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Capture the final value on the edge into FIN so DOUT is valid alongside DONE.
      if (state_next == FIN) dout_next = w_next;
   end

   assign STAGE_IN = w;
   assign DOUT     = dout;

endmodule
